// File: rtl/dcm_prog_ctrl_if.sv
// Requester-side and DCM-side signals of the DCM programming arbiter.
// slave = the controller, master = the requesters plus the DCM it drives.
interface dcm_prog_ctrl_if #(
  parameter int N_REQ  = 2,
  parameter int PROG_W = 3
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*PROG_W-1:0] req_prog;
  logic [N_REQ-1:0]        grant;
  logic                    ack;
  logic                    err;
  logic                    busy;
  logic [PROG_W-1:0]       dcm_prog_in;
  logic                    dcm_update;
  logic [PROG_W-1:0]       dcm_prog_out;
  logic [PROG_W-1:0]       cur_prog;
  logic                    cur_valid;

  modport slave (
    input  req, req_prog, dcm_prog_out,
    output grant, ack, err, busy, dcm_prog_in, dcm_update, cur_prog, cur_valid
  );

  modport master (
    output req, req_prog, dcm_prog_out,
    input  grant, ack, err, busy, dcm_prog_in, dcm_update, cur_prog, cur_valid
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Round-robin owner of a single DCM programming port: update pulse, echo wait with
// bounded retry, settle, then ack/err. Optional macro DCM_PROG_SKIP_EN skips same-code updates.
module dcm_prog_ctrl #(
  parameter int N_REQ          = 2,
  parameter int PROG_W         = 3,
  parameter int UPD_CYCLES     = 10,
  parameter int SETTLE_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 2
) (
  input  logic            clk,
  input  logic            rst,
  dcm_prog_ctrl_if.slave  bus
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (UPD_CYCLES > SETTLE_CYCLES)
                           ? ((UPD_CYCLES > TIMEOUT_CYCLES) ? UPD_CYCLES : TIMEOUT_CYCLES)
                           : ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ATT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_SETTLE, S_DONE, S_FAIL
  } state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic               r_ack;
  logic               r_err;
  logic               r_busy;
  logic [PROG_W-1:0]  r_prog_in;
  logic               r_update;
  logic [PROG_W-1:0]  r_cur_prog;
  logic               r_cur_valid;
  logic [PROG_W-1:0]  r_target;
  logic [IDX_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ATT_W-1:0]   r_attempt;

  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_next_rr;
  logic [N_REQ-1:0]   w_onehot;
  logic [PROG_W-1:0]  w_code;

  // Winner = first set request at or after the round-robin pointer, wrapping.
  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      k = int'(r_rr) + j;
      if (k >= N_REQ) k = k - N_REQ;
      if (!w_found && bus.req[k]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(k);
      end
    end
    w_next_rr = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    w_onehot  = N_REQ'(1) << w_idx;
    w_code    = bus.req_prog[w_idx*PROG_W +: PROG_W];
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_prog_in   <= '0;
      r_update    <= 1'b0;
      r_cur_prog  <= '0;
      r_cur_valid <= 1'b0;
      r_target    <= '0;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_attempt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= w_onehot;
            r_target  <= w_code;
            r_rr      <= w_next_rr;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_attempt <= '0;
`ifdef DCM_PROG_SKIP_EN
            if (r_cur_valid && (w_code == r_cur_prog)) begin
              r_state     <= S_DONE;
              r_ack       <= 1'b1;
              r_cur_valid <= 1'b1;
            end else
`endif
            begin
              r_state   <= S_LOAD;
              r_update  <= 1'b1;
              r_prog_in <= w_code;
            end
          end
        end
        S_LOAD: begin
          if (r_cnt == CNT_W'(UPD_CYCLES - 1)) begin
            r_state  <= S_WAIT;
            r_update <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.dcm_prog_out == r_target) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cnt <= '0;
            if (r_attempt < ATT_W'(MAX_RETRY)) begin
              r_attempt <= r_attempt + ATT_W'(1);
              r_state   <= S_LOAD;
              r_update  <= 1'b1;
            end else begin
              r_state     <= S_FAIL;
              r_err       <= 1'b1;
              r_cur_valid <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          // The echo is not re-checked here; the DCM only has to match once.
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state     <= S_DONE;
            r_ack       <= 1'b1;
            r_cur_prog  <= r_target;
            r_cur_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_FAIL: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.ack         = r_ack;
  assign bus.err         = r_err;
  assign bus.busy        = r_busy;
  assign bus.dcm_prog_in = r_prog_in;
  assign bus.dcm_update  = r_update;
  assign bus.cur_prog    = r_cur_prog;
  assign bus.cur_valid   = r_cur_valid;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Scoreboard bench for dcm_prog_ctrl: directed requests against a small DCM echo model;
// a monitor pops expected {grant, err, cur_prog, cur_valid} on every ack/err pulse.
module tb_dcm_prog_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcm_prog_ctrl_if #(.N_REQ(2), .PROG_W(3)) ifc ();

  dcm_prog_ctrl #(
    .N_REQ(2), .PROG_W(3), .UPD_CYCLES(10), .SETTLE_CYCLES(100),
    .TIMEOUT_CYCLES(255), .MAX_RETRY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct packed {
    logic [1:0] grant;
    logic       is_err;
    logic [2:0] prog;
    logic       valid;
  } resp_t;

  resp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  function automatic void expect_resp(input logic [1:0] g, input logic e,
                                      input logic [2:0] p, input logic v);
    resp_t r;
    r = '{grant: g, is_err: e, prog: p, valid: v};
    sb.push_back(r);
  endfunction

  // DCM model: a new update pulse drops the echo; echo returns 2 cycles after update falls.
  logic stuck    = 1'b0;
  logic upd_seen = 1'b0;
  int   echo_cnt = 0;
  always @(negedge clk) begin
    if (ifc.dcm_update && !upd_seen) ifc.dcm_prog_out = '0;
    if (!ifc.dcm_update && upd_seen) begin
      echo_cnt = 2;
    end else if (echo_cnt > 0) begin
      echo_cnt--;
      if (echo_cnt == 0 && !stuck) ifc.dcm_prog_out = ifc.dcm_prog_in;
    end
    upd_seen = ifc.dcm_update;
  end

  // Update pulse counter and width, grant-to-response latency.
  int cyc = 0, upd_run = 0, last_width = 0, pulses = 0;
  int grant_cyc = 0, last_lat = 0;
  logic [1:0] prev_grant = '0;
  always @(negedge clk) begin
    cyc++;
    if (ifc.dcm_update) begin
      upd_run++;
    end else if (upd_run != 0) begin
      last_width = upd_run;
      pulses++;
      upd_run = 0;
    end
    if (ifc.grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
    prev_grant = ifc.grant;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && (ifc.ack || ifc.err)) begin
      resp_t act_r, exp_r;
      last_lat = cyc - grant_cyc;
      act_r = '{grant: ifc.grant, is_err: ifc.err && !ifc.ack,
                prog: ifc.cur_prog, valid: ifc.cur_valid};
      check("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        check("resp", 32'(act_r), 32'(exp_r));
      end
    end
  end

  // Raise the masked requests and drop each one once its ack/err is seen with its grant bit.
  task automatic do_ops(input logic [1:0] mask, input logic [5:0] codes);
    int n;
    @(negedge clk);
    ifc.req_prog = codes;
    ifc.req      = mask;
    n = 0;
    while (ifc.req != 2'b00 && n < 3000) begin
      @(negedge clk);
      n++;
      if (ifc.ack || ifc.err) ifc.req = ifc.req & ~ifc.grant;
    end
    check("ops_complete", 32'(ifc.req), 32'd0);
    ifc.req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int n;
    ifc.req          = '0;
    ifc.req_prog     = '0;
    ifc.dcm_prog_out = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_ctrl", 32'({ifc.grant, ifc.busy, ifc.ack, ifc.err, ifc.dcm_update, ifc.cur_valid}), 32'd0);
    check("reset_prog", 32'({ifc.dcm_prog_in, ifc.cur_prog}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-LOAD clears outputs at once.
    @(negedge clk);
    ifc.req_prog = 6'b000_101;
    ifc.req      = 2'b01;
    n = 0;
    while (!ifc.dcm_update && n < 20) begin @(negedge clk); n++; end
    check("load_reached", 32'(ifc.dcm_update), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midload_reset", 32'({ifc.dcm_update, ifc.grant, ifc.busy, ifc.cur_valid}), 32'd0);
    ifc.req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({ifc.busy, ifc.grant}), 32'd0);

    // Simultaneous pair with rr pointer at 0: req0 then req1.
    expect_resp(2'b01, 1'b0, 3'b001, 1'b1);
    expect_resp(2'b10, 1'b0, 3'b110, 1'b1);
    do_ops(2'b11, {3'b110, 3'b001});

    // Single request: 10-cycle pulse, echo 2 cycles after fall, 100 settle -> 10+3+100 = 113.
    pulses = 0;
    expect_resp(2'b01, 1'b0, 3'b101, 1'b1);
    do_ops(2'b01, {3'b000, 3'b101});
    check("upd_width", 32'(last_width), 32'd10);
    check("upd_pulses_single", 32'(pulses), 32'd1);
    check("ack_latency", 32'(last_lat), 32'd113);
    check("prog_in_held", 32'(ifc.dcm_prog_in), 32'd5);

    // rr pointer now at 1: the next simultaneous pair starts with req1.
    expect_resp(2'b10, 1'b0, 3'b010, 1'b1);
    expect_resp(2'b01, 1'b0, 3'b011, 1'b1);
    do_ops(2'b11, {3'b010, 3'b011});

    // Stuck echo: 3 attempts of 10 update + 255 wait = 795 cycles, then err, cur_prog kept.
    stuck  = 1'b1;
    pulses = 0;
    expect_resp(2'b10, 1'b1, 3'b011, 1'b0);
    do_ops(2'b10, {3'b011, 3'b000});
    check("retry_pulses", 32'(pulses), 32'd3);
    check("err_latency", 32'(last_lat), 32'd795);
    stuck = 1'b0;

    // Same code twice.
    pulses = 0;
    expect_resp(2'b01, 1'b0, 3'b001, 1'b1);
    do_ops(2'b01, {3'b000, 3'b001});
    expect_resp(2'b01, 1'b0, 3'b001, 1'b1);
    do_ops(2'b01, {3'b000, 3'b001});
`ifdef DCM_PROG_SKIP_EN
    check("same_code_pulses", 32'(pulses), 32'd1);
`else
    check("same_code_pulses", 32'(pulses), 32'd2);
`endif

    // Request dropped during SETTLE still completes with ack.
    expect_resp(2'b10, 1'b0, 3'b100, 1'b1);
    @(negedge clk);
    ifc.req_prog = {3'b100, 3'b000};
    ifc.req      = 2'b10;
    n = 0;
    while (ifc.grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    check("busy_in_settle", 32'(ifc.busy), 32'd1);
    ifc.req = 2'b00;
    n = 0;
    while (!ifc.ack && n < 200) begin @(negedge clk); n++; end
    check("ack_after_drop", 32'(ifc.ack), 32'd1);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
